// File: rtl/axi_lite_reg_slave_if.sv
// AXI-lite bus bundle for one register-slave port: AW, W, B, AR and R channels.
// The master modport is the interconnect side; the slave modport is the register file.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8:0]   wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register file: CTRL0/CTRL1 read-write, STATUS/WRCNT read-only.
// Independent single-outstanding write and read FSMs.
module axi_lite_reg_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] CTRL0_RST  = '0
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    axi_lite_reg_slave_if.slave   s_axi,
    input  logic [DATA_WIDTH-1:0] status_in,
    output logic [DATA_WIDTH-1:0] ctrl0_out,
    output logic [DATA_WIDTH-1:0] ctrl1_out
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WADDR_W = ADDR_WIDTH - 2;

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE     = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        REG_CTRL0,
        REG_CTRL1,
        REG_STATUS,
        REG_WRCNT,
        REG_NONE
    } reg_sel_t;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Word address only: the byte-lane bits [1:0] never reach the decoder.
    function automatic reg_sel_t decode(input logic [WADDR_W-1:0] waddr);
        reg_sel_t sel;
        if (waddr[WADDR_W-1:2] != '0) begin
            sel = REG_NONE;
        end else begin
            case (waddr[1:0])
                2'd0:    sel = REG_CTRL0;
                2'd1:    sel = REG_CTRL1;
                2'd2:    sel = REG_STATUS;
                default: sel = REG_WRCNT;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_strb(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    w_state_t              w_state;
    r_state_t              r_state;
    logic                  aw_held;
    logic                  w_held;
    logic [WADDR_W-1:0]    aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  bvalid_q;
    logic [RESP_WIDTH-1:0] bresp_q;
    logic                  rvalid_q;
    logic [RESP_WIDTH-1:0] rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] ctrl0_q;
    logic [DATA_WIDTH-1:0] ctrl1_q;
    logic [DATA_WIDTH-1:0] wrcnt_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  wr_fire;
    logic [WADDR_W-1:0]    wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  unused_bits;

    // Ready lines drop combinationally during reset so no handshake can land in that cycle.
    assign s_axi.awready = (w_state == W_IDLE) && !aw_held && !s_axi_areset;
    assign s_axi.wready  = (w_state == W_IDLE) && !w_held && !s_axi_areset;
    assign s_axi.arready = (r_state == R_IDLE) && !s_axi_areset;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;

    // A held beat takes priority; otherwise the beat handshaking this cycle is used directly.
    assign wr_addr = aw_held ? aw_addr_q : s_axi.awaddr[ADDR_WIDTH-1:2];
    assign wr_data = w_held ? w_data_q : s_axi.wdata;
    assign wr_strb = w_held ? w_strb_q : s_axi.wstrb[STRB_W-1:0];
    assign wr_fire = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign s_axi.bvalid = bvalid_q;
    assign s_axi.bresp  = bresp_q;
    assign s_axi.rvalid = rvalid_q;
    assign s_axi.rresp  = rresp_q;
    assign s_axi.rdata  = rdata_q;
    assign ctrl0_out    = ctrl0_q;
    assign ctrl1_out    = ctrl1_q;

    assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.wstrb[STRB_W]};

    always_ff @(posedge s_axi_aclk) begin
        if (aw_hs) aw_addr_q <= s_axi.awaddr[ADDR_WIDTH-1:2];
        if (w_hs) begin
            w_data_q <= s_axi.wdata;
            w_strb_q <= s_axi.wstrb[STRB_W-1:0];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            ctrl0_q  <= CTRL0_RST;
            ctrl1_q  <= '0;
            wrcnt_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bvalid_q <= 1'b1;
                        w_state  <= W_RESP;
                        case (decode(wr_addr))
                            REG_CTRL0: begin
                                ctrl0_q <= merge_strb(ctrl0_q, wr_data, wr_strb);
                                wrcnt_q <= wrcnt_q + CNT_ONE;
                                bresp_q <= RESP_OKAY;
                            end
                            REG_CTRL1: begin
                                ctrl1_q <= merge_strb(ctrl1_q, wr_data, wr_strb);
                                wrcnt_q <= wrcnt_q + CNT_ONE;
                                bresp_q <= RESP_OKAY;
                            end
                            REG_STATUS, REG_WRCNT: bresp_q <= RESP_SLVERR;
                            default:               bresp_q <= RESP_DECERR;
                        endcase
                    end else begin
                        if (aw_hs) aw_held <= 1'b1;
                        if (w_hs)  w_held  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read data samples the registers before any same-edge write lands (non-blocking order).
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rvalid_q <= 1'b1;
                        r_state  <= R_DATA;
                        rresp_q  <= RESP_OKAY;
                        case (decode(s_axi.araddr[ADDR_WIDTH-1:2]))
                            REG_CTRL0:  rdata_q <= ctrl0_q;
                            REG_CTRL1:  rdata_q <= ctrl1_q;
                            REG_STATUS: rdata_q <= status_in;
                            REG_WRCNT:  rdata_q <= wrcnt_q;
                            default: begin
                                rdata_q <= '0;
                                rresp_q <= RESP_DECERR;
                            end
                        endcase
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: handshakes, decode, strobes, read/write ordering, reset.
module tb_axi_lite_reg_slave;
    localparam logic [31:0] C0_RST = 32'h0000_005A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] status_in;
    logic [31:0] ctrl0_out;
    logic [31:0] ctrl1_out;
    int          errors = 0;
    int          checks = 0;

    axi_lite_reg_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_WIDTH(3)) bus ();

    axi_lite_reg_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESP_WIDTH(3),
        .CTRL0_RST (C0_RST)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .s_axi       (bus),
        .status_in   (status_in),
        .ctrl0_out   (ctrl0_out),
        .ctrl1_out   (ctrl1_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            input logic [2:0] exp_resp, input string tag);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check({tag, ".bvalid"}, 64'(bus.bvalid), 64'd1);
        check({tag, ".bresp"}, 64'(bus.bresp), 64'(exp_resp));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check({tag, ".bdone"}, 64'(bus.bvalid), 64'd0);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data,
                           input logic [2:0] exp_resp, input string tag);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b0;
        check({tag, ".rvalid"}, 64'(bus.rvalid), 64'd1);
        check({tag, ".rdata"}, 64'(bus.rdata), 64'(exp_data));
        check({tag, ".rresp"}, 64'(bus.rresp), 64'(exp_resp));
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check({tag, ".rdone"}, 64'(bus.rvalid), 64'd0);
    endtask

    initial begin
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        status_in   = 32'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst.awready", 64'(bus.awready), 64'd0);
        check("rst.wready", 64'(bus.wready), 64'd0);
        check("rst.arready", 64'(bus.arready), 64'd0);
        check("rst.bvalid", 64'(bus.bvalid), 64'd0);
        check("rst.rvalid", 64'(bus.rvalid), 64'd0);
        check("rst.rdata", 64'(bus.rdata), 64'd0);
        check("rst.ctrl0", 64'(ctrl0_out), 64'(C0_RST));
        check("rst.ctrl1", 64'(ctrl1_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.awready", 64'(bus.awready), 64'd1);
        check("idle.wready", 64'(bus.wready), 64'd1);
        check("idle.arready", 64'(bus.arready), 64'd1);

        // AW and W in the same cycle
        do_write(8'h00, 32'hA5A5_A5A5, 5'h0F, 3'd0, "wr_c0");
        check("wr_c0.ctrl0", 64'(ctrl0_out), 64'hA5A5_A5A5);
        do_read(8'h0C, 32'd1, 3'd0, "wrcnt1");

        // W arrives three cycles before AW, partial strobes
        bus.wdata  = 32'h1122_3344;
        bus.wstrb  = 5'h05;
        bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("wfirst.wready", 64'(bus.wready), 64'd0);
        check("wfirst.awready", 64'(bus.awready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("wfirst.nobvalid", 64'(bus.bvalid), 64'd0);
            @(negedge clk);
        end
        bus.awaddr  = 8'h04;
        bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        check("wfirst.bvalid", 64'(bus.bvalid), 64'd1);
        check("wfirst.bresp", 64'(bus.bresp), 64'd0);
        check("wfirst.ctrl1", 64'(ctrl1_out), 64'h0022_0044);
        check("wfirst.busy_awready", 64'(bus.awready), 64'd0);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("wfirst.bdone", 64'(bus.bvalid), 64'd0);

        // STATUS read with back-pressure; status_in moves after sampling
        status_in   = 32'hDEAD_BEEF;
        bus.araddr  = 8'h08;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b0;
        status_in   = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            check("stat.rvalid_hold", 64'(bus.rvalid), 64'd1);
            check("stat.rdata_hold", 64'(bus.rdata), 64'hDEAD_BEEF);
            check("stat.rresp_hold", 64'(bus.rresp), 64'd0);
            check("stat.arready_busy", 64'(bus.arready), 64'd0);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("stat.rdone", 64'(bus.rvalid), 64'd0);

        // Error responses
        do_write(8'h0C, 32'hFFFF_FFFF, 5'h0F, 3'd2, "wr_wrcnt");
        do_write(8'h08, 32'hFFFF_FFFF, 5'h0F, 3'd2, "wr_status");
        do_write(8'h80, 32'hFFFF_FFFF, 5'h0F, 3'd3, "wr_unmap");
        do_read(8'h40, 32'd0, 3'd3, "rd_unmap");
        do_read(8'h0C, 32'd2, 3'd0, "wrcnt2");
        check("err.ctrl0", 64'(ctrl0_out), 64'hA5A5_A5A5);
        check("err.ctrl1", 64'(ctrl1_out), 64'h0022_0044);

        // Zero / MSB-only strobes still count; low address bits ignored
        do_write(8'h00, 32'hFFFF_FFFF, 5'h00, 3'd0, "strb0");
        check("strb0.ctrl0", 64'(ctrl0_out), 64'hA5A5_A5A5);
        do_write(8'h04, 32'hFFFF_FFFF, 5'h10, 3'd0, "strbmsb");
        check("strbmsb.ctrl1", 64'(ctrl1_out), 64'h0022_0044);
        do_write(8'h03, 32'h0000_0007, 5'h0F, 3'd0, "lowbits");
        check("lowbits.ctrl0", 64'(ctrl0_out), 64'h0000_0007);
        do_read(8'h07, 32'h0022_0044, 3'd0, "rd_lowbits");
        do_read(8'h0C, 32'd5, 3'd0, "wrcnt5");

        // Same-edge write and read of CTRL0 returns the old value
        bus.awaddr  = 8'h00;
        bus.wdata   = 32'h0000_0001;
        bus.wstrb   = 5'h0F;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 8'h00;
        bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        check("rw.rvalid", 64'(bus.rvalid), 64'd1);
        check("rw.rdata_old", 64'(bus.rdata), 64'h7);
        check("rw.bvalid", 64'(bus.bvalid), 64'd1);
        check("rw.ctrl0_new", 64'(ctrl0_out), 64'h1);
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        do_read(8'h00, 32'h1, 3'd0, "rw.reread");
        do_read(8'h0C, 32'd6, 3'd0, "wrcnt6");

        // Reset while a write response is pending
        bus.awaddr  = 8'h04;
        bus.wdata   = 32'h0000_CAFE;
        bus.wstrb   = 5'h0F;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("rstmid.bvalid_pre", 64'(bus.bvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.bvalid", 64'(bus.bvalid), 64'd0);
        check("rstmid.ctrl0", 64'(ctrl0_out), 64'(C0_RST));
        check("rstmid.ctrl1", 64'(ctrl1_out), 64'd0);
        check("rstmid.awready", 64'(bus.awready), 64'd0);
        check("rstmid.arready", 64'(bus.arready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.awready_idle", 64'(bus.awready), 64'd1);
        check("rstmid.wready_idle", 64'(bus.wready), 64'd1);
        check("rstmid.arready_idle", 64'(bus.arready), 64'd1);
        check("rstmid.bvalid_idle", 64'(bus.bvalid), 64'd0);
        do_read(8'h0C, 32'd0, 3'd0, "rstmid.wrcnt");
        do_read(8'h00, C0_RST, 3'd0, "rstmid.ctrl0_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
